// File: rtl/universal_shift_register_pkg.sv
// Shared constants for the universal shift register: mode codes, burst
// directions and FSM state encoding.
package universal_shift_register_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 mux (hold / upper neighbour / lower neighbour / load)
// into a DFF; 1-cycle latency, no backpressure.
module usr_bit_cell
  import universal_shift_register_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       upper,
  input  logic       lower,
  input  logic       load,
  output logic       q
);

  // A right shift pulls from the more significant neighbour, a left shift
  // from the less significant one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      unique case (sel)
        MODE_SHR:  q <= upper;
        MODE_SHL:  q <= lower;
        MODE_LOAD: q <= load;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift/load register with a self-timed N-position burst shifter.
// Mode actions take effect on the next edge; inputs are ignored while busy.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic             start,
  input  logic             burst_dir,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] dataout,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic [1:0]       sel;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] eff_len;

  assign eff_len = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

  // A start request wins over mode and holds the register for that edge.
  always_comb begin
    sel = MODE_HOLD;
    if (state == ST_SHIFT) begin
      sel = (dir == DIR_LEFT) ? MODE_SHL : MODE_SHR;
    end else if (!start) begin
      sel = mode;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dir   <= DIR_RIGHT;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              cnt   <= eff_len;
              dir   <= burst_dir;
              busy  <= 1'b1;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic upper;
    logic lower;
    if (i == WIDTH - 1) begin : g_top
      assign upper = serial_in_right;
    end else begin : g_mid_hi
      assign upper = q[i+1];
    end
    if (i == 0) begin : g_bot
      assign lower = serial_in_left;
    end else begin : g_mid_lo
      assign lower = q[i-1];
    end
    usr_bit_cell u_cell (
      .clock (clock),
      .reset (reset),
      .sel   (sel),
      .upper (upper),
      .lower (lower),
      .load  (data[i]),
      .q     (q[i])
    );
  end

  assign dataout          = q;
  assign serial_out_right = q[0];
  assign serial_out_left  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed and randomized bench for universal_shift_register (WIDTH=4) against
// a remaining-shift-count reference model.
module tb_universal_shift_register;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [W-1:0]  data;
  logic          serial_in_right;
  logic          serial_in_left;
  logic          start;
  logic          burst_dir;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  dataout;
  logic          serial_out_right;
  logic          serial_out_left;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Reference model: register value, shifts still owed, burst direction, done flag.
  logic [W-1:0] m_q;
  int           m_rem;
  logic         m_dir;
  logic         m_done;

  universal_shift_register #(.WIDTH(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .data             (data),
    .serial_in_right  (serial_in_right),
    .serial_in_left   (serial_in_left),
    .start            (start),
    .burst_dir        (burst_dir),
    .burst_len        (burst_len),
    .dataout          (dataout),
    .serial_out_right (serial_out_right),
    .serial_out_left  (serial_out_left),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] shr(input logic [W-1:0] v, input logic b);
    return (v >> 1) | (W'(b) << (W - 1));
  endfunction

  function automatic logic [W-1:0] shl(input logic [W-1:0] v, input logic b);
    return (v << 1) | W'(b);
  endfunction

  task automatic model_step();
    logic nd;
    nd = 1'b0;
    if (m_rem > 0) begin
      m_q = (m_dir) ? shl(m_q, serial_in_left) : shr(m_q, serial_in_right);
      m_rem--;
      if (m_rem == 0) nd = 1'b1;
    end else if (start) begin
      if (burst_len == 0) nd = 1'b1;
      else begin
        m_rem = (int'(burst_len) > W) ? W : int'(burst_len);
        m_dir = burst_dir;
      end
    end else begin
      case (mode)
        2'b01:   m_q = shr(m_q, serial_in_right);
        2'b10:   m_q = shl(m_q, serial_in_left);
        2'b11:   m_q = data;
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".dataout"}, 32'(dataout), 32'(m_q));
    check({tag, ".sor"}, 32'(serial_out_right), 32'(m_q[0]));
    check({tag, ".sol"}, 32'(serial_out_left), 32'(m_q[W-1]));
    check({tag, ".busy"}, 32'(busy), 32'(m_rem > 0));
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic cyc(input string tag, input logic [1:0] m, input logic [W-1:0] d,
                     input logic sr, input logic sl, input logic st, input logic bd,
                     input logic [CW-1:0] bl);
    mode = m; data = d; serial_in_right = sr; serial_in_left = sl;
    start = st; burst_dir = bd; burst_len = bl;
    @(posedge clock);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic model_reset();
    m_q = '0; m_rem = 0; m_dir = 1'b0; m_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; data = '0; serial_in_right = 1'b0;
    serial_in_left = 1'b0; start = 1'b0; burst_dir = 1'b0; burst_len = '0;
    model_reset();
    #12;
    compare_all("reset");
    reset = 1'b0;
    #10;

    // Per-cycle modes
    cyc("load", 2'b11, 4'b1011, 0, 0, 0, 0, 0);
    check("load_const", 32'(dataout), 32'h b);
    cyc("shr", 2'b01, 4'b0000, 0, 0, 0, 0, 0);
    check("shr_const", 32'(dataout), 32'h5);
    check("shr_sor", 32'(serial_out_right), 32'h1);
    cyc("shl", 2'b10, 4'b0000, 0, 1, 0, 0, 0);
    check("shl_const", 32'(dataout), 32'hb);
    for (int i = 0; i < 3; i++) cyc("hold", 2'b00, 4'b0110, 1, 1, 0, 0, 0);
    check("hold_const", 32'(dataout), 32'hb);

    // Right burst of 2
    cyc("ld1001", 2'b11, 4'b1001, 0, 0, 0, 0, 0);
    cyc("rb_start", 2'b00, 4'b0000, 1, 0, 1, 0, 3'd2);
    check("rb_start_busy", 32'(busy), 32'h1);
    cyc("rb_e1", 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    check("rb_e1_const", 32'(dataout), 32'hc);
    cyc("rb_e2", 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    check("rb_e2_const", 32'(dataout), 32'he);
    check("rb_done", 32'(done), 32'h1);
    cyc("rb_idle", 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    check("rb_done_clr", 32'(done), 32'h0);

    // Clamped left burst
    cyc("ld1111", 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    cyc("cl_start", 2'b00, 4'b0000, 0, 0, 1, 1, 3'd7);
    for (int i = 0; i < 4; i++) cyc("cl_shift", 2'b00, 4'b0000, 0, 0, 0, 0, 0);
    check("cl_const", 32'(dataout), 32'h0);
    check("cl_done", 32'(done), 32'h1);
    cyc("cl_after", 2'b00, 4'b0000, 0, 0, 0, 0, 0);

    // Zero length
    cyc("ld0110", 2'b11, 4'b0110, 0, 0, 0, 0, 0);
    cyc("z_start", 2'b01, 4'b0000, 1, 1, 1, 0, 3'd0);
    check("z_busy", 32'(busy), 32'h0);
    check("z_done", 32'(done), 32'h1);
    check("z_data", 32'(dataout), 32'h6);

    // Isolation while busy, then restart in the done cycle
    cyc("iso_start", 2'b00, 4'b0000, 1, 0, 1, 0, 3'd3);
    cyc("iso_b1", 2'b11, 4'b0101, 0, 1, 1, 1, 3'd1);
    cyc("iso_b2", 2'b11, 4'b0101, 1, 0, 1, 1, 3'd2);
    cyc("iso_b3", 2'b11, 4'b0101, 0, 1, 1, 1, 3'd4);
    check("iso_done", 32'(done), 32'h1);
    cyc("iso_restart", 2'b00, 4'b0000, 0, 1, 1, 1, 3'd1);
    check("iso_rebusy", 32'(busy), 32'h1);
    cyc("iso_r1", 2'b00, 4'b0000, 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a burst
    cyc("rst_ld", 2'b11, 4'b1010, 0, 0, 0, 0, 0);
    cyc("rst_start", 2'b00, 4'b0000, 1, 1, 1, 0, 3'd4);
    cyc("rst_b1", 2'b00, 4'b0000, 1, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_data", 32'(dataout), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    check("rst_async_done", 32'(done), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rst_post", 2'b00, 4'b0000, 1, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 5) == 0), 1'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the 4-bit PIPO register.
- WIDTH-bit register with four per-cycle modes: hold, shift right, shift left and parallel load.
- Adds a self-timed burst shifter: one start pulse shifts the register N positions, with busy/done status.
- Sits between datapath sources and serialisers/deserialisers; the serial outputs allow cascading instances.

Parameters:
- WIDTH, 4, register width in bits (legal range: 2 or more).
- CNT_W, $clog2(WIDTH+1), width of burst_len and the internal burst counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  per-cycle operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- data  in  WIDTH  parallel load value
- serial_in_right  in  1  bit entering the MSB on a right shift
- serial_in_left  in  1  bit entering the LSB on a left shift
- start  in  1  single-cycle burst request
- burst_dir  in  1  burst direction: 0 right, 1 left
- burst_len  in  CNT_W  number of positions to shift in the burst
- dataout  out  WIDTH  register contents
- serial_out_right  out  1  equals dataout[0]
- serial_out_left  out  1  equals dataout[WIDTH-1]
- busy  out  1  high while a burst is shifting
- done  out  1  one-cycle pulse after a burst completes

Behaviour:
- Reset (asynchronous, active-high): dataout=0, busy=0, done=0, counter=0, FSM=IDLE. Asserting reset mid-burst aborts the burst immediately; no done pulse is produced.
- All state changes occur on the rising edge of clock. Outputs are registered; serial outputs are pure combinational taps of dataout.
- Mode actions, applied in IDLE when start=0:
  - Shift right: dataout <= {serial_in_right, dataout[WIDTH-1:1]}.
  - Shift left: dataout <= {dataout[WIDTH-2:0], serial_in_left}.
  - Parallel load: dataout <= data.
  - Hold: no change.
- FSM states are IDLE and SHIFT.
- IDLE with start=1 and burst_len>0:
  - Latch burst_dir and the effective length L = min(burst_len, WIDTH) into the counter.
  - Go to SHIFT with busy=1.
  - dataout holds on this edge; start takes priority over mode.
- IDLE with start=1 and burst_len=0: stay in IDLE, dataout holds, done=1 on the next cycle.
- SHIFT, on each edge:
  - Shift one position in the latched direction, using the live serial_in_* sampled that cycle.
  - Decrement the counter.
  - When the counter goes from 1 to 0: return to IDLE, busy=0, and assert done=1 for exactly one cycle.
- Latency: with start sampled at edge 0, shifts occur at edges 1..L. busy is high after edge 0 through edge L; done is high for the cycle after edge L.
- While busy=1, mode, data, start, burst_dir and burst_len are ignored. start is not queued.
- In the done cycle the FSM is in IDLE. mode and start are honoured, so back-to-back bursts are allowed with one idle-cycle gap.
- A burst with L=WIDTH fully replaces the contents with serial input bits.

Decomposition:
- Shared package holds:
  - Mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Direction constants DIR_RIGHT=0, DIR_LEFT=1.
  - FSM state encodings ST_IDLE and ST_SHIFT.
- One sub-module is natural: usr_bit_cell. It is a 4:1 mux feeding a DFF with asynchronous active-high reset, selecting hold/left-neighbour/right-neighbour/load. The parent instantiates WIDTH cells and contains the FSM, counter and select decode.

Test Plan (WIDTH=4):
- Reset mid-operation: reset=1 asynchronously during a burst → dataout=0000, busy=0, done stays 0, and no further shifts after release.
- Per-cycle modes:
  - mode=11 with data=1011 → dataout=1011.
  - Then mode=01 with serial_in_right=0 → 0101, serial_out_right=1.
  - Then mode=10 with serial_in_left=1 → 1011.
  - Then mode=00 for 3 cycles → stays 1011.
- Right burst: dataout=1001, start with burst_dir=0, burst_len=2, serial_in_right=1 → busy for 2 cycles, dataout 1100 then 1110, done pulse 1 cycle, then IDLE.
- Clamp: burst_len=7, burst_dir=1, serial_in_left=0 from dataout=1111 → exactly 4 shifts, dataout=0000, done after edge 4.
- Zero length: start with burst_len=0 → busy never rises, done=1 the next cycle, dataout unchanged.
- Input isolation while busy: start and mode=11 driven during a burst → ignored. A start in the done cycle launches a new burst; confirm busy re-rises next cycle.
